vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
Multi-product vending controller that sequences the coin-to-product flow.
- Accumulates credit from ₹1/₹2 coin pulses.
- Accepts a product selection when credit covers the price.
- Drives a dispenser through a req/ack handshake.
- Returns the remaining credit as change, one coin per handshake.
Sits between the coin-acceptor/keypad front end and the dispenser and change-hopper mechanisms.

Parameters:
PRICE_A, 3, price of product A in ₹ (must be 1..MAX_CREDIT)
PRICE_B, 4, price of product B in ₹ (must be 1..MAX_CREDIT)
CREDIT_W, 4, credit register width in bits
MAX_CREDIT, 9, maximum credit held; must be < 2**CREDIT_W
TIMEOUT_CYC, 255, idle-credit timeout in cycles (used only with VEND_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
coin1  input  1  one-cycle pulse: ₹1 coin inserted
coin2  input  1  one-cycle pulse: ₹2 coin inserted
sel_a  input  1  one-cycle pulse: product A selected
sel_b  input  1  one-cycle pulse: product B selected
cancel  input  1  one-cycle pulse: refund request
disp_ack  input  1  dispenser completed the product drop
chg_ack  input  1  hopper released the requested change coin
disp_req  output  1  dispense request, held until acked
disp_sel  output  1  product being dispensed: 0 = A, 1 = B
chg1_req  output  1  request one ₹1 change coin
chg2_req  output  1  request one ₹2 change coin
coin_reject  output  1  one-cycle pulse: coin(s) returned uncredited
credit  output  CREDIT_W  current credit in ₹
busy  output  1  high in VEND or CHANGE

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, credit is 0, state is IDLE.
- Reset asserted mid-operation aborts the transaction at once; credit is discarded and all requests drop.

States: IDLE (credit = 0), CREDIT (credit > 0), VEND, CHANGE.

Coin acceptance (IDLE/CREDIT only):
- An accepted coin is added to credit on the next edge.
- coin1 and coin2 in the same cycle: both are added if credit + 3 <= MAX_CREDIT; otherwise both are rejected.
- A single coin whose value would push credit above MAX_CREDIT is rejected; credit is unchanged.
- Rejection means coin_reject = 1 for exactly one cycle, on the cycle after the insertion.
- Any coin arriving in VEND or CHANGE is rejected the same way.
- IDLE -> CREDIT when credit becomes nonzero.

Selection (CREDIT only):
- If sel_a and credit >= PRICE_A: credit -= PRICE_A, disp_sel = 0, disp_req = 1, go to VEND.
- If sel_b and credit >= PRICE_B: the same with PRICE_B and disp_sel = 1.
- sel_a and sel_b together: sel_a has priority.
- A selection with insufficient credit is ignored; no state change, no error.
- A coin and a select in the same cycle: the coin is processed and the select is ignored.
- Selections in IDLE, VEND or CHANGE are ignored.

cancel:
- In CREDIT: go to CHANGE with the full credit as the refund.
- Ignored in IDLE, VEND and CHANGE.
- cancel together with a valid select: cancel wins.

VEND:
- disp_req and disp_sel stay stable until disp_ack is sampled high.
- On ack, disp_req falls on the next edge.
- Next state is CHANGE if credit > 0, else IDLE.
- disp_ack seen outside VEND is ignored.

CHANGE:
- Issue chg2_req if credit >= 2, else chg1_req; never both at once.
- Hold the request until chg_ack is sampled.
- On ack: the request drops on the next edge and credit decreases by 2 or 1.
- After at least one idle cycle, issue the next request if credit > 0; otherwise go to IDLE.
- Change order is always ₹2 coins first, then at most one ₹1 coin.

Invariant: credit <= MAX_CREDIT at all times. Credit arithmetic never wraps.

Optional Feature:
Macro: VEND_TIMEOUT_EN
- Defined:
  - An inactivity counter runs while in CREDIT and is cleared by any accepted coin or state exit.
  - When it reaches TIMEOUT_CYC, the block goes to CHANGE and refunds all credit, exactly as for cancel.
- Not defined: no counter exists, and CREDIT is held indefinitely.

Test Plan:
- Coin sequence and sale: coin2, coin1, sel_a (PRICE_A = 3) -> credit 2, then 3; disp_req = 1, disp_sel = 0; credit 0 after the select; after disp_ack the state returns to IDLE with no change requests.
- Over-credit rejection: credit 8, then coin2 -> coin_reject pulses 1 cycle and credit stays 8. Then coin1 -> credit 9.
- Sale with change: credit 9, sel_b (PRICE_B = 4), disp_ack -> credit 5. Then chg2_req, ack, chg2_req, ack, chg1_req, ack -> credit 0, state IDLE.
- Boundary selects: credit 2 and sel_a -> ignored, credit stays 2. Credit 4 with sel_a and sel_b together -> disp_sel = 0, credit 1.
- Cancel and blocked coins: credit 3, then cancel -> chg2_req then chg1_req. A coin1 arriving during CHANGE -> coin_reject pulses and credit is unaffected.
- Reset mid-VEND: rst driven low while disp_req = 1 -> disp_req = 0, credit = 0 and state IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vend_controller.sv
// Coin-to-product vending sequencer: credit accumulation, selection, dispense handshake, change payout.
// Optional idle-credit refund timer is compiled in with VEND_TIMEOUT_EN.
module vend_controller #(
   parameter int PRICE_A     = 3,
   parameter int PRICE_B     = 4,
   parameter int CREDIT_W    = 4,
   parameter int MAX_CREDIT  = 9,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin1,
   input  logic                coin2,
   input  logic                sel_a,
   input  logic                sel_b,
   input  logic                cancel,
   input  logic                disp_ack,
   input  logic                chg_ack,
   output logic                disp_req,
   output logic                disp_sel,
   output logic                chg1_req,
   output logic                chg2_req,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   if (PRICE_A < 1 || PRICE_A > MAX_CREDIT || PRICE_B < 1 || PRICE_B > MAX_CREDIT ||
       MAX_CREDIT >= (1 << CREDIT_W) || TIMEOUT_CYC < 1) begin : g_param_err
      $error("vend_controller: illegal parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

   state_t              state, state_nx;
   logic [CREDIT_W-1:0] credit_nx;
   logic                disp_req_nx, disp_sel_nx, chg1_nx, chg2_nx, reject_nx;
   logic                coin_any, coin_fit, timeout;
   logic [1:0]          coin_val;
   logic [CREDIT_W:0]   coin_sum;

   // One extra bit so the over-credit test can never be fooled by wraparound.
   assign coin_any = coin1 | coin2;
   assign coin_val = {coin2, coin1};
   assign coin_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_val[1] ? (coin_val[0] ? 3 : 2) : (coin_val[0] ? 1 : 0));
   assign coin_fit = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);

   // Largest coin first: {chg2, chg1}.
   function automatic logic [1:0] chg_pick(input logic [CREDIT_W-1:0] c);
      return {c >= CREDIT_W'(2), c == CREDIT_W'(1)};
   endfunction

`ifdef VEND_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;
   logic            coin_ok;

   assign coin_ok = coin_any && coin_fit;
   assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         to_cnt <= '0;
      else if (state != S_CREDIT || state_nx != S_CREDIT || coin_ok)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + TO_W'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nx    = state;
      credit_nx   = credit;
      disp_req_nx = disp_req;
      disp_sel_nx = disp_sel;
      chg1_nx     = chg1_req;
      chg2_nx     = chg2_req;
      reject_nx   = 1'b0;
      case (state)
         S_IDLE, S_CREDIT: begin
            // A coin pulse takes the cycle; selects and cancel alongside it are dropped.
            if (coin_any) begin
               if (coin_fit) begin
                  credit_nx = coin_sum[CREDIT_W-1:0];
                  state_nx  = S_CREDIT;
               end else begin
                  reject_nx = 1'b1;
               end
            end else if (state == S_CREDIT) begin
               if (cancel || timeout) begin
                  state_nx           = S_CHANGE;
                  {chg2_nx, chg1_nx} = chg_pick(credit);
               end else if (sel_a && credit >= CREDIT_W'(PRICE_A)) begin
                  credit_nx   = credit - CREDIT_W'(PRICE_A);
                  disp_req_nx = 1'b1;
                  disp_sel_nx = 1'b0;
                  state_nx    = S_VEND;
               end else if (sel_b && credit >= CREDIT_W'(PRICE_B)) begin
                  credit_nx   = credit - CREDIT_W'(PRICE_B);
                  disp_req_nx = 1'b1;
                  disp_sel_nx = 1'b1;
                  state_nx    = S_VEND;
               end
            end
         end
         S_VEND: begin
            reject_nx = coin_any;
            if (disp_ack) begin
               disp_req_nx = 1'b0;
               if (credit != '0) begin
                  state_nx           = S_CHANGE;
                  {chg2_nx, chg1_nx} = chg_pick(credit);
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_CHANGE: begin
            reject_nx = coin_any;
            if (chg1_req || chg2_req) begin
               if (chg_ack) begin
                  chg1_nx   = 1'b0;
                  chg2_nx   = 1'b0;
                  credit_nx = credit - (chg2_req ? CREDIT_W'(2) : CREDIT_W'(1));
               end
            end else if (credit != '0) begin
               {chg2_nx, chg1_nx} = chg_pick(credit);
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         credit      <= '0;
         disp_req    <= 1'b0;
         disp_sel    <= 1'b0;
         chg1_req    <= 1'b0;
         chg2_req    <= 1'b0;
         coin_reject <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nx;
         credit      <= credit_nx;
         disp_req    <= disp_req_nx;
         disp_sel    <= disp_sel_nx;
         chg1_req    <= chg1_nx;
         chg2_req    <= chg2_nx;
         coin_reject <= reject_nx;
         busy        <= (state_nx == S_VEND) || (state_nx == S_CHANGE);
      end
   end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: per-cycle comparison against a transaction-level model,
// plus literal expectations at the interesting points of each scenario.
module tb_vend_controller;
   localparam int PA = 3, PB = 4, CW = 4, MAXC = 9;
   localparam logic [6:0] NOP = 7'b0000000, C1 = 7'b1000000, C2 = 7'b0100000,
                          SA  = 7'b0010000, SB = 7'b0001000, CN = 7'b0000100,
                          DA  = 7'b0000010, CA = 7'b0000001;

   logic clk = 1'b0, rst = 1'b0;
   logic coin1 = 0, coin2 = 0, sel_a = 0, sel_b = 0, cancel = 0, disp_ack = 0, chg_ack = 0;
   logic disp_req, disp_sel, chg1_req, chg2_req, coin_reject, busy;
   logic [CW-1:0] credit;
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   vend_controller #(.PRICE_A(PA), .PRICE_B(PB), .CREDIT_W(CW), .MAX_CREDIT(MAXC), .TIMEOUT_CYC(255)) dut (
      .clk(clk), .rst(rst), .coin1(coin1), .coin2(coin2), .sel_a(sel_a), .sel_b(sel_b),
      .cancel(cancel), .disp_ack(disp_ack), .chg_ack(chg_ack), .disp_req(disp_req),
      .disp_sel(disp_sel), .chg1_req(chg1_req), .chg2_req(chg2_req),
      .coin_reject(coin_reject), .credit(credit), .busy(busy));

   // Transaction-level model: mode 0 = taking money, 1 = dispensing, 2 = paying out a coin list.
   int m_credit, m_mode, m_chg;
   bit m_disp, m_dsel, m_rej;
   int chg_q[$];

   task automatic start_change();
      int r;
      r = m_credit;
      m_mode = 2;
      chg_q.delete();
      while (r >= 2) begin chg_q.push_back(2); r -= 2; end
      if (r == 1) chg_q.push_back(1);
      m_chg = chg_q.pop_front();
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_credit = 0; m_mode = 0; m_chg = 0; m_disp = 0; m_dsel = 0; m_rej = 0; chg_q.delete();
      end else begin
         m_rej = 0;
         if (m_mode == 0) begin
            if (coin1 || coin2) begin
               int v;
               v = int'(coin1) + 2 * int'(coin2);
               if (m_credit + v <= MAXC) m_credit += v; else m_rej = 1;
            end else if (m_credit > 0) begin
               if (cancel) start_change();
               else if (sel_a && m_credit >= PA) begin m_credit -= PA; m_disp = 1; m_dsel = 0; m_mode = 1; end
               else if (sel_b && m_credit >= PB) begin m_credit -= PB; m_disp = 1; m_dsel = 1; m_mode = 1; end
            end
         end else begin
            if (coin1 || coin2) m_rej = 1;
            if (m_mode == 1) begin
               if (disp_ack) begin
                  m_disp = 0;
                  if (m_credit > 0) start_change(); else m_mode = 0;
               end
            end else if (m_chg != 0) begin
               if (chg_ack) begin m_credit -= m_chg; m_chg = 0; end
            end else if (chg_q.size() > 0) begin
               m_chg = chg_q.pop_front();
            end else begin
               m_mode = 0;
            end
         end
      end
   end

   initial forever begin
      logic [10:0] got, exp;
      @(negedge clk);
      got = {disp_req, disp_sel, chg1_req, chg2_req, coin_reject, busy, credit};
      exp = {m_disp, m_dsel, m_chg == 1, m_chg == 2, m_rej, m_mode != 0, 4'(m_credit)};
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL model @%0t: got dreq/dsel/c1/c2/rej/busy/credit=%b expected %b", $time, got, exp);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic step(input logic [6:0] v);
      {coin1, coin2, sel_a, sel_b, cancel, disp_ack, chg_ack} = v;
      @(negedge clk);
      {coin1, coin2, sel_a, sel_b, cancel, disp_ack, chg_ack} = NOP;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 24; i++) begin
         if (chg1_req || chg2_req) step(CA);
         else if (busy) step(NOP);
         else break;
      end
      chk({nm, "_idle"}, busy, 0);
      chk({nm, "_credit0"}, credit, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_credit", credit, 0); chk("rst_dreq", disp_req, 0); chk("rst_busy", busy, 0);
      chk("rst_chg", {chg2_req, chg1_req}, 0); chk("rst_rej", coin_reject, 0);
      rst = 1'b1;
      @(negedge clk);

      // simple sale, no change
      step(C2); chk("sale_c2", credit, 2);
      step(C1); chk("sale_c1", credit, 3);
      step(SA); chk("sale_dreq", disp_req, 1); chk("sale_dsel", disp_sel, 0); chk("sale_credit", credit, 0);
      step(NOP); chk("sale_hold", disp_req, 1);
      step(DA); chk("sale_drop", disp_req, 0); chk("sale_busy", busy, 0); chk("sale_nochg", {chg2_req, chg1_req}, 0);

      // over-credit rejection
      repeat (4) step(C2);
      chk("over_8", credit, 8);
      step(C2); chk("over_rej", coin_reject, 1); chk("over_keep", credit, 8);
      step(NOP); chk("over_rej_pulse", coin_reject, 0);
      step(C1); chk("over_9", credit, 9);

      // sale with change 5 = 2 + 2 + 1
      step(SB); chk("chg_credit", credit, 5); chk("chg_dsel", disp_sel, 1);
      step(DA); chk("chg_dreq", disp_req, 0); chk("chg_first2", chg2_req, 1);
      step(CA); chk("chg_after1", credit, 3); chk("chg_gap", chg2_req, 0);
      step(NOP); chk("chg_second2", chg2_req, 1);
      step(CA); chk("chg_after2", credit, 1);
      step(NOP); chk("chg_one", chg1_req, 1); chk("chg_not2", chg2_req, 0);
      step(CA); chk("chg_after3", credit, 0);
      step(NOP); chk("chg_done", busy, 0);

      // boundary selects
      step(C2); step(SA); chk("bnd_ignored", credit, 2); chk("bnd_noreq", disp_req, 0);
      step(C2); step(SA | SB); chk("bnd_prio_sel", disp_sel, 0); chk("bnd_prio_cr", credit, 1);
      step(DA); chk("bnd_chg1", chg1_req, 1);
      drain("bnd");

      // cancel and coin blocked during change
      step(C2); step(C1);
      step(CN); chk("cn_chg2", chg2_req, 1); chk("cn_credit", credit, 3);
      step(C1); chk("cn_rej", coin_reject, 1); chk("cn_keep", credit, 3);
      step(CA); chk("cn_after", credit, 1);
      step(NOP); chk("cn_chg1", chg1_req, 1);
      drain("cn");

      // dual coins, dual-coin overflow, cancel beats select
      step(C1 | C2); chk("dual_add", credit, 3);
      step(C2); step(C2); step(C1); chk("dual_8", credit, 8);
      step(C1 | C2); chk("dual_rej", coin_reject, 1); chk("dual_keep", credit, 8);
      step(CN | SA); chk("cnsel_chg", chg2_req, 1); chk("cnsel_nodisp", disp_req, 0);
      drain("cnsel");

      // asynchronous reset in the middle of a vend
      step(C1); step(C2); step(SA); chk("mid_dreq", disp_req, 1);
      #2 rst = 1'b0;
      #1 chk("mid_rst_dreq", disp_req, 0); chk("mid_rst_credit", credit, 0); chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      step(C1); chk("post_rst", credit, 1);
      step(CN);
      drain("post");

      repeat (2) step(NOP);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
